// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the I-cache / D-cache main-memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_BUSY = 2'd1,
    ARB_ACK  = 2'd2
  } arb_state_t;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_IC   = 2'd1,
    GNT_DC   = 2'd2
  } grant_t;

  localparam int MEM_LAT_W = 4;
  localparam logic [MEM_LAT_W-1:0] LAT_ZERO = 4'd0;
  localparam logic [MEM_LAT_W-1:0] LAT_ONE  = 4'd1;

  // Tie-break: with rr_en the grant goes to whoever was not served last.
  function automatic grant_t pick_winner(input logic ic_req, input logic dc_req,
                                         input grant_t last_grant, input logic rr_en);
    grant_t w;
    if (ic_req && dc_req) begin
      if (rr_en && (last_grant == GNT_DC)) begin
        w = GNT_IC;
      end else begin
        w = GNT_DC;
      end
    end else if (dc_req) begin
      w = GNT_DC;
    end else if (ic_req) begin
      w = GNT_IC;
    end else begin
      w = GNT_NONE;
    end
    return w;
  endfunction

endpackage

// File: rtl/mem_latency_timer.sv
// Down-counter that measures the memory access window; done marks the last busy cycle.
module mem_latency_timer
  import mem_arb_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_b,
  input  logic                 load,
  input  logic [MEM_LAT_W-1:0] load_val,
  output logic                 done
);

  logic [MEM_LAT_W-1:0] count_q, count_d;

  // Load on grant, otherwise count down and rest at zero.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (count_q != LAT_ZERO) begin
      count_d = count_q - LAT_ONE;
    end else begin
      count_d = count_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      count_q <= LAT_ZERO;
    end else begin
      count_q <= count_d;
    end
  end

  assign done = (count_q == LAT_ONE);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the main-memory port between I-cache and D-cache, one access at a time.
// Build option MEM_ARB_ROUND_ROBIN_EN alternates ties; otherwise the D-cache wins ties.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MEM_LATENCY = 2,
  parameter int ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic              ic_req,
  input  logic [ADDR_W-1:0] ic_addr,
  output logic [3:0][7:0]   ic_rdata,
  output logic              ic_ack,
  input  logic              dc_req,
  input  logic              dc_we,
  input  logic [ADDR_W-1:0] dc_addr,
  input  logic [3:0][7:0]   dc_wdata,
  output logic [3:0][7:0]   dc_rdata,
  output logic              dc_ack,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_write_en,
  output logic [3:0][7:0]   mem_data_in,
  input  logic [3:0][7:0]   mem_data_out
);

`ifdef MEM_ARB_ROUND_ROBIN_EN
  localparam logic RR_EN = 1'b1;
`else
  localparam logic RR_EN = 1'b0;
`endif
  localparam logic [MEM_LAT_W-1:0] LAT_LOAD = MEM_LAT_W'(MEM_LATENCY);

  arb_state_t        state_q, state_d;
  grant_t            win_q, win_d, last_grant_q, last_grant_d, req_win;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              mem_we_q, mem_we_d;
  logic [3:0][7:0]   mem_wdata_q, mem_wdata_d;
  logic [3:0][7:0]   ic_rdata_q, ic_rdata_d, dc_rdata_q, dc_rdata_d;
  logic              ic_ack_q, ic_ack_d, dc_ack_q, dc_ack_d;
  logic              timer_load, timer_done;

  mem_latency_timer u_timer (
    .clk      (clk),
    .rst_b    (rst_b),
    .load     (timer_load),
    .load_val (LAT_LOAD),
    .done     (timer_done)
  );

  // State and datapath registers; reset clears every output.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q      <= ARB_IDLE;
      win_q        <= GNT_NONE;
      last_grant_q <= GNT_IC;
      mem_addr_q   <= {ADDR_W{1'b0}};
      mem_we_q     <= 1'b0;
      mem_wdata_q  <= 32'h0;
      ic_rdata_q   <= 32'h0;
      dc_rdata_q   <= 32'h0;
      ic_ack_q     <= 1'b0;
      dc_ack_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      win_q        <= win_d;
      last_grant_q <= last_grant_d;
      mem_addr_q   <= mem_addr_d;
      mem_we_q     <= mem_we_d;
      mem_wdata_q  <= mem_wdata_d;
      ic_rdata_q   <= ic_rdata_d;
      dc_rdata_q   <= dc_rdata_d;
      ic_ack_q     <= ic_ack_d;
      dc_ack_q     <= dc_ack_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ARB_IDLE: begin
        if (ic_req || dc_req) begin
          state_d = ARB_BUSY;
        end else begin
          state_d = ARB_IDLE;
        end
      end
      ARB_BUSY: begin
        if (timer_done) begin
          state_d = ARB_ACK;
        end else begin
          state_d = ARB_BUSY;
        end
      end
      ARB_ACK: state_d = ARB_IDLE;
      default: state_d = ARB_IDLE;
    endcase
  end

  // Output and datapath next values; requester inputs are only looked at in idle.
  always_comb begin
    req_win      = pick_winner(ic_req, dc_req, last_grant_q, RR_EN);
    win_d        = win_q;
    last_grant_d = last_grant_q;
    mem_addr_d   = mem_addr_q;
    mem_we_d     = mem_we_q;
    mem_wdata_d  = mem_wdata_q;
    ic_rdata_d   = ic_rdata_q;
    dc_rdata_d   = dc_rdata_q;
    ic_ack_d     = 1'b0;
    dc_ack_d     = 1'b0;
    timer_load   = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        if (req_win == GNT_DC) begin
          win_d       = GNT_DC;
          mem_addr_d  = dc_addr;
          mem_we_d    = dc_we;
          mem_wdata_d = dc_wdata;
          timer_load  = 1'b1;
        end else if (req_win == GNT_IC) begin
          win_d      = GNT_IC;
          mem_addr_d = ic_addr;
          mem_we_d   = 1'b0;
          timer_load = 1'b1;
        end else begin
          win_d    = GNT_NONE;
          mem_we_d = 1'b0;
        end
      end
      ARB_BUSY: begin
        if (timer_done) begin
          mem_we_d = 1'b0;
          if (win_q == GNT_IC) begin
            ic_rdata_d = mem_data_out;
            ic_ack_d   = 1'b1;
          end else if (win_q == GNT_DC) begin
            dc_rdata_d = mem_data_out;
            dc_ack_d   = 1'b1;
          end else begin
            dc_ack_d = 1'b0;
          end
        end else begin
          mem_we_d = mem_we_q;
        end
      end
      ARB_ACK: begin
        last_grant_d = win_q;
        mem_we_d     = 1'b0;
      end
      default: begin
        mem_we_d = 1'b0;
      end
    endcase
  end

  assign mem_addr     = mem_addr_q;
  assign mem_write_en = mem_we_q;
  assign mem_data_in  = mem_wdata_q;
  assign ic_rdata     = ic_rdata_q;
  assign dc_rdata     = dc_rdata_q;
  assign ic_ack       = ic_ack_q;
  assign dc_ack       = dc_ack_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: occupancy-window model checked every cycle plus directed literal checks.
module tb_mem_port_arbiter;

  localparam int LAT = 2;

  logic clk = 1'b0;
  logic rst_b = 1'b0;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic            ic_req = 1'b0, dc_req = 1'b0, dc_we = 1'b0;
  logic [31:0]     ic_addr = 32'h0, dc_addr = 32'h0;
  logic [3:0][7:0] dc_wdata = 32'h0;
  logic [31:0]     mem_base = 32'h0;
  logic            mem_ramp = 1'b0;
  logic [3:0][7:0] mem_data_out;
  logic [3:0][7:0] ic_rdata, dc_rdata, mem_data_in;
  logic            ic_ack, dc_ack, mem_write_en;
  logic [31:0]     mem_addr;

  logic            dc1_req = 1'b0;
  logic            zero_bit = 1'b0;
  logic [31:0]     dc1_addr = 32'h0, zero_addr = 32'h0;
  logic [3:0][7:0] zero_data = 32'h0;
  logic [3:0][7:0] ic1_rdata, dc1_rdata, mem1_data_in;
  logic            ic1_ack, dc1_ack, mem1_write_en;
  logic [31:0]     mem1_addr;

  assign mem_data_out = mem_ramp ? (mem_base + 32'(cyc)) : mem_base;

  mem_port_arbiter #(.MEM_LATENCY(LAT), .ADDR_W(32)) dut (
    .clk(clk), .rst_b(rst_b),
    .ic_req(ic_req), .ic_addr(ic_addr), .ic_rdata(ic_rdata), .ic_ack(ic_ack),
    .dc_req(dc_req), .dc_we(dc_we), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
    .dc_rdata(dc_rdata), .dc_ack(dc_ack),
    .mem_addr(mem_addr), .mem_write_en(mem_write_en), .mem_data_in(mem_data_in),
    .mem_data_out(mem_data_out)
  );

  mem_port_arbiter #(.MEM_LATENCY(1), .ADDR_W(32)) dut1 (
    .clk(clk), .rst_b(rst_b),
    .ic_req(zero_bit), .ic_addr(zero_addr), .ic_rdata(ic1_rdata), .ic_ack(ic1_ack),
    .dc_req(dc1_req), .dc_we(zero_bit), .dc_addr(dc1_addr), .dc_wdata(zero_data),
    .dc_rdata(dc1_rdata), .dc_ack(dc1_ack),
    .mem_addr(mem1_addr), .mem_write_en(mem1_write_en), .mem_data_in(mem1_data_in),
    .mem_data_out(mem_data_out)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Model: an access granted in idle cycle g occupies cycles g..g+LAT+1.
  int          m_active = 0, m_g = 0, m_win = 0, m_last = 1;
  logic        m_we_t = 1'b0;
  logic [31:0] m_addr_t = 32'h0, m_wdata_t = 32'h0, m_cap = 32'h0;
  logic [31:0] e_addr = 32'h0, e_wdata = 32'h0, e_ic_rd = 32'h0, e_dc_rd = 32'h0;

  always @(negedge clk) begin
    logic e_we, e_ica, e_dca;
    if (!rst_b) begin
      m_active = 0; m_last = 1;
      e_addr = 32'h0; e_wdata = 32'h0; e_ic_rd = 32'h0; e_dc_rd = 32'h0;
    end else if (m_active != 0) begin
      if (cyc == m_g + 1) begin
        e_addr = m_addr_t;
        if (m_win == 2) e_wdata = m_wdata_t;
      end
      if (cyc == m_g + LAT + 1) begin
        if (m_win == 1) e_ic_rd = m_cap;
        else e_dc_rd = m_cap;
      end
    end
    e_we  = rst_b && (m_active != 0) && m_we_t && (cyc >= m_g + 1) && (cyc <= m_g + LAT);
    e_ica = rst_b && (m_active != 0) && (m_win == 1) && (cyc == m_g + LAT + 1);
    e_dca = rst_b && (m_active != 0) && (m_win == 2) && (cyc == m_g + LAT + 1);
    chk("m_mem_addr", mem_addr, e_addr);
    chk("m_mem_data_in", mem_data_in, e_wdata);
    chk("m_mem_write_en", mem_write_en, e_we);
    chk("m_ic_ack", ic_ack, e_ica);
    chk("m_dc_ack", dc_ack, e_dca);
    chk("m_ic_rdata", ic_rdata, e_ic_rd);
    chk("m_dc_rdata", dc_rdata, e_dc_rd);
    if (rst_b) begin
      if ((m_active != 0) && (cyc == m_g + LAT)) m_cap = mem_data_out;
      if ((m_active != 0) && (cyc == m_g + LAT + 1)) begin
        m_last = m_win;
        m_active = 0;
      end else if ((m_active == 0) && (ic_req || dc_req)) begin
        if (ic_req && dc_req) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
          m_win = (m_last == 1) ? 2 : 1;
`else
          m_win = 2;
`endif
        end else begin
          m_win = dc_req ? 2 : 1;
        end
        m_active  = 1;
        m_g       = cyc;
        m_addr_t  = (m_win == 2) ? dc_addr : ic_addr;
        m_we_t    = (m_win == 2) ? dc_we : 1'b0;
        m_wdata_t = dc_wdata;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ack(input string nm, input int max, output int which, output int at);
    which = 0;
    at = -1;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (ic_ack) begin which = 1; at = cyc; break; end
      if (dc_ack) begin which = 2; at = cyc; break; end
    end
    if (which == 0) chk({nm, "_ack_timeout"}, 64'd0, 64'd1);
  endtask

  initial begin
    int s, who, at, n;
    int seq[4];
    int acks[4];
    logic [4:0] wen_log;
    logic ic1_seen;

    repeat (3) @(negedge clk);
    chk("reset_addr", mem_addr, 32'h0);
    chk("reset_ctrl", {ic_ack, dc_ack, mem_write_en}, 3'b000);
    chk("reset_rdata", {ic_rdata, dc_rdata}, 64'h0);
    chk("reset_wdata", mem_data_in, 32'h0);
    tick();
    rst_b = 1'b1;
    tick();

    // Tie right after reset: D-cache first in both configurations.
    mem_ramp = 1'b1; mem_base = 32'h5000_0000;
    ic_addr = 32'h80; dc_addr = 32'h300; dc_we = 1'b0; dc_wdata = 32'hCAFE_0001;
    ic_req = 1'b1; dc_req = 1'b1; s = cyc;
    wait_ack("tie1", 10, who, at);
    chk("tie1_who", who, 2);
    chk("tie1_lat", at - s, 3);
    chk("tie1_rdata", dc_rdata, mem_base + 32'(s + 2));
    tick(); dc_req = 1'b0;
    wait_ack("tie2", 10, who, at);
    chk("tie2_who", who, 1);
    chk("tie2_lat", at - s, 7);
    chk("tie2_rdata", ic_rdata, mem_base + 32'(s + 6));
    tick(); ic_req = 1'b0;
    tick();

    // Both held continuously for four grants.
    dc_we = 1'b1; dc_wdata = 32'h0BAD_F00D; dc_addr = 32'h400; ic_addr = 32'h500;
    ic_req = 1'b1; dc_req = 1'b1; s = cyc;
    for (int k = 0; k < 4; k++) begin
      wait_ack("hold", 10, who, at);
      seq[k] = who;
      chk("hold_spacing", at - s, 3 + 4 * k);
    end
`ifdef MEM_ARB_ROUND_ROBIN_EN
    chk("hold_seq", {seq[0][3:0], seq[1][3:0], seq[2][3:0], seq[3][3:0]}, 16'h2121);
`else
    chk("hold_seq", {seq[0][3:0], seq[1][3:0], seq[2][3:0], seq[3][3:0]}, 16'h2222);
`endif
    tick(); ic_req = 1'b0; dc_req = 1'b0; dc_we = 1'b0;
    tick();

    // Single I-cache read.
    mem_ramp = 1'b0; mem_base = 32'hDEAD_BEEF;
    ic_addr = 32'h0000_0040; ic_req = 1'b1; s = cyc;
    wait_ack("ic_rd", 10, who, at);
    chk("ic_rd_who", who, 1);
    chk("ic_rd_lat", at - s, 3);
    chk("ic_rd_data", ic_rdata, 32'hDEAD_BEEF);
    chk("ic_rd_byte0", ic_rdata[0], 8'hEF);
    chk("ic_rd_addr", mem_addr, 32'h0000_0040);
    tick(); ic_req = 1'b0;
    tick();

    // Single D-cache write.
    dc_addr = 32'h0000_1004; dc_wdata = 32'h1234_5678; dc_we = 1'b1; dc_req = 1'b1; s = cyc;
    wen_log = 5'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      wen_log[i] = mem_write_en;
      if (i == 1) chk("dc_wr_data", mem_data_in, 32'h1234_5678);
      if (i == 1) chk("dc_wr_addr", mem_addr, 32'h0000_1004);
      if (i == 3) chk("dc_wr_acks", {ic_ack, dc_ack}, 2'b01);
    end
    tick(); dc_req = 1'b0; dc_we = 1'b0;
    @(negedge clk);
    wen_log[4] = mem_write_en;
    chk("dc_wr_wen_window", wen_log, 5'b00110);
    tick();

    // Address change during busy is ignored.
    dc_addr = 32'h100; dc_we = 1'b0; dc_req = 1'b1; s = cyc;
    tick();
    dc_addr = 32'h200; dc_we = 1'b1;
    @(negedge clk);
    chk("hold_addr_busy", mem_addr, 32'h100);
    chk("hold_wen_busy", mem_write_en, 1'b0);
    wait_ack("hold_addr", 10, who, at);
    chk("hold_addr_lat", at - s, 3);
    chk("hold_addr_ack", mem_addr, 32'h100);
    tick(); dc_req = 1'b0; dc_we = 1'b0;
    tick();

    // Reset in the first busy cycle of a write, then re-issue.
    dc_addr = 32'h2000; dc_wdata = 32'hAABB_CCDD; dc_we = 1'b1; dc_req = 1'b1;
    tick();
    #1;
    chk("rst_mid_wen_before", mem_write_en, 1'b1);
    rst_b = 1'b0; dc_req = 1'b0;
    #1;
    chk("rst_mid_wen_after", mem_write_en, 1'b0);
    chk("rst_mid_outs", {ic_ack, dc_ack, mem_addr, mem_data_in}, 66'h0);
    @(posedge clk); #1;
    rst_b = 1'b1;
    tick();
    dc_req = 1'b1; s = cyc;
    wait_ack("reissue", 10, who, at);
    chk("reissue_who", who, 2);
    chk("reissue_lat", at - s, 3);
    tick(); dc_req = 1'b0; dc_we = 1'b0;
    tick();

    // MEM_LATENCY=1 instance: sustained D-cache requests.
    mem_ramp = 1'b1; mem_base = 32'h7700_0000;
    dc1_addr = 32'h44; dc1_req = 1'b1; s = cyc; n = 0; ic1_seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      ic1_seen = ic1_seen | ic1_ack;
      if (dc1_ack && n < 4) begin
        acks[n] = cyc;
        if (n == 0) chk("l1_rdata", dc1_rdata, mem_base + 32'(s + 1));
        if (n == 0) chk("l1_addr", mem1_addr, 32'h44);
        n++;
      end
    end
    chk("l1_ack_count", n, 4);
    for (int k = 0; k < 4; k++) chk("l1_ack_cycle", acks[k] - s, 2 + 3 * k);
    chk("l1_no_ic", {ic1_seen, mem1_write_en}, 2'b00);
    chk("l1_idle_outs", {ic1_rdata, mem1_data_in}, 64'h0);
    tick(); dc1_req = 1'b0;
    repeat (4) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
